iob_ram_arbiter: RTL

Round-robin arbiter that shares one port of `iob_ram_tdp` (or any single-cycle-read synchronous RAM port) among `N_REQ` requesters. Each requester issues single-word reads or writes through a valid/ready handshake. The arbiter drives the RAM port and routes read data back to the owning requester one cycle later. An optional lock input lets a requester keep the port for back-to-back bursts.

---
 rtl/iob_ram_arbiter_if.sv | 31 +++
 rtl/iob_ram_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/iob_ram_arbiter_if.sv
// Requester-side handshake and RAM-port signals shared between the arbiter and its environment.
// Requester fields are packed per index: requester i uses [i*W +: W].
interface iob_ram_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    ram_en;
  logic                    ram_we;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_din;
  logic [DATA_W-1:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/iob_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among N_REQ requesters,
// with optional grant lock for bursts and one-cycle read response routing.
module iob_ram_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input logic              clk,
  input logic              rst,
  iob_ram_arbiter_if.slave bus
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  lock_id;
  logic [PTR_W-1:0]  pend_id;
  logic              lock_valid;
  logic              pend_valid;

  logic              grant_any;
  logic [PTR_W-1:0]  grant_id;
  logic              grant_we;
  logic              grant_lock;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;
  logic [N_REQ-1:0]  ready;
  logic [N_REQ-1:0]  resp;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return PTR_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    if (int'(g) == N_REQ - 1) return '0;
    return g + PTR_W'(1);
  endfunction

  // A live lock overrides the rotation; otherwise search from rr_ptr upward.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    if (lock_valid && bus.req_valid[lock_id]) begin
      grant_any = 1'b1;
      grant_id  = lock_id;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_any && bus.req_valid[rr_index(rr_ptr, k)]) begin
          grant_any = 1'b1;
          grant_id  = rr_index(rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    ready       = '0;
    grant_we    = 1'b0;
    grant_lock  = 1'b0;
    grant_addr  = '0;
    grant_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && grant_id == PTR_W'(i)) begin
        ready[i]    = 1'b1;
        grant_we    = bus.req_we[i];
        grant_lock  = bus.req_lock[i];
        grant_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        grant_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.ram_en    = grant_any & ~rst;
  assign bus.ram_we    = grant_we & ~rst;
  assign bus.ram_addr  = grant_addr;
  assign bus.ram_din   = grant_wdata;

  // The pointer advances even under lock so rotation resumes fairly on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
      pend_valid <= 1'b0;
      pend_id    <= '0;
    end else if (grant_any) begin
      rr_ptr     <= next_ptr(grant_id);
      lock_valid <= grant_lock;
      if (grant_lock) lock_id <= grant_id;
      pend_valid <= ~grant_we;
      pend_id    <= grant_id;
    end else begin
      pend_valid <= 1'b0;
      if (lock_valid && !bus.req_valid[lock_id]) lock_valid <= 1'b0;
    end
  end

  always_comb begin
    resp = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pend_valid && pend_id == PTR_W'(i)) resp[i] = 1'b1;
    end
  end

  assign bus.resp_valid = resp;
  assign bus.resp_rdata = bus.ram_dout;
endmodule
